// File: rtl/inst_encoder_if.sv
// Handshake bundles for the instruction encoder: field-set input channel and
// encoded-word output channel.

interface inst_encoder_in_if;
  logic        valid;
  logic        ready;
  logic [2:0]  fmt;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm;

  modport master (output valid, fmt, rd, rs1, rs2, funct3, funct7, imm, input ready);
  modport slave  (input valid, fmt, rd, rs1, rs2, funct3, funct7, imm, output ready);
endinterface

interface inst_encoder_out_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              valid;
  logic              ready;
  logic [31:0]       inst;
  logic [ADDR_W-1:0] addr;
  logic              err;

  modport master (output valid, inst, addr, err, input ready);
  modport slave  (input valid, inst, addr, err, output ready);
endinterface

// File: rtl/inst_encoder.sv
// Streaming RV32 instruction encoder: two-stage valid/ready pipeline that packs
// field sets into instruction words, tags each with a byte address and NOPs bad ones.

module inst_encoder #(
  parameter int unsigned       ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter logic [31:0]       NOP_WORD  = 32'h0000_0013
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       clear_i,
  inst_encoder_in_if.slave           fld_if,
  inst_encoder_out_if.master         word_if,
  output logic [7:0]                 err_cnt_o
);

  typedef enum logic [2:0] {
    FMT_R   = 3'd0,
    FMT_I   = 3'd1,
    FMT_LD  = 3'd2,
    FMT_SD  = 3'd3,
    FMT_BEQ = 3'd4
  } fmt_e;

  // Stage A: captured fields plus the range/legality verdict
  logic              a_valid_q, a_valid_d;
  logic [2:0]        a_fmt_q;
  logic [4:0]        a_rd_q, a_rs1_q, a_rs2_q;
  logic [2:0]        a_f3_q;
  logic [6:0]        a_f7_q;
  logic [11:0]       a_imm_q;
  logic              a_ok_q;

  // Stage B: encoded word, error tag, address and error counter
  logic              b_valid_q, b_valid_d;
  logic [31:0]       b_inst_q;
  logic              b_err_q;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        err_cnt_q, err_cnt_d;

  logic              a_load, b_load, out_fire;
  logic              imm_fits, fmt_legal, in_ok;
  logic [31:0]       enc_word;

  assign out_fire = b_valid_q & word_if.ready;
  assign b_load   = a_valid_q & (~b_valid_q | word_if.ready);
  assign fld_if.ready = ~a_valid_q | ~b_valid_q | word_if.ready;
  assign a_load   = fld_if.valid & fld_if.ready;

  // 12-bit signed range: bits 31..11 must all replicate the sign
  assign imm_fits  = (&fld_if.imm[31:11]) | ~(|fld_if.imm[31:11]);
  assign fmt_legal = (fld_if.fmt <= 3'd4);
  assign in_ok     = fmt_legal & ((fld_if.fmt == FMT_R) | imm_fits);

  always_comb begin
    enc_word = NOP_WORD;
    case (a_fmt_q)
      FMT_R:   enc_word = {a_f7_q, a_rs2_q, a_rs1_q, a_f3_q, a_rd_q, 7'b0110011};
      FMT_I:   enc_word = {a_imm_q, a_rs1_q, a_f3_q, a_rd_q, 7'b0010011};
      FMT_LD:  enc_word = {a_imm_q, a_rs1_q, a_f3_q, a_rd_q, 7'b0000011};
      FMT_SD:  enc_word = {a_imm_q[11:5], a_rs2_q, a_rs1_q, a_f3_q, a_imm_q[4:0], 7'b0100011};
      // imm is a halfword offset, so imm[11:0] maps onto byte-offset bits 12..1
      FMT_BEQ: enc_word = {a_imm_q[11], a_imm_q[9:4], a_rs2_q, a_rs1_q, a_f3_q,
                           a_imm_q[3:0], a_imm_q[10], 7'b1100011};
      default: enc_word = NOP_WORD;
    endcase
    if (!a_ok_q) enc_word = NOP_WORD;
  end

  always_comb begin
    a_valid_d = a_valid_q;
    b_valid_d = b_valid_q;
    addr_d    = addr_q;
    err_cnt_d = err_cnt_q;
    if (a_load)        a_valid_d = 1'b1;
    else if (b_load)   a_valid_d = 1'b0;
    if (b_load)        b_valid_d = 1'b1;
    else if (out_fire) b_valid_d = 1'b0;
    if (out_fire) begin
      addr_d = addr_q + ADDR_W'(4);
      if (b_err_q && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;
    end
    if (clear_i) begin
      a_valid_d = 1'b0;
      b_valid_d = 1'b0;
      addr_d    = BASE_ADDR;
      err_cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      a_valid_q <= 1'b0;
      a_fmt_q   <= '0;
      a_rd_q    <= '0;
      a_rs1_q   <= '0;
      a_rs2_q   <= '0;
      a_f3_q    <= '0;
      a_f7_q    <= '0;
      a_imm_q   <= '0;
      a_ok_q    <= 1'b0;
      b_valid_q <= 1'b0;
      b_inst_q  <= '0;
      b_err_q   <= 1'b0;
      addr_q    <= BASE_ADDR;
      err_cnt_q <= '0;
    end else begin
      a_valid_q <= a_valid_d;
      b_valid_q <= b_valid_d;
      addr_q    <= addr_d;
      err_cnt_q <= err_cnt_d;
      if (a_load) begin
        a_fmt_q <= fld_if.fmt;
        a_rd_q  <= fld_if.rd;
        a_rs1_q <= fld_if.rs1;
        a_rs2_q <= fld_if.rs2;
        a_f3_q  <= fld_if.funct3;
        a_f7_q  <= fld_if.funct7;
        a_imm_q <= fld_if.imm[11:0];
        a_ok_q  <= in_ok;
      end
      if (b_load) begin
        b_inst_q <= enc_word;
        b_err_q  <= ~a_ok_q;
      end
    end
  end

  assign word_if.valid = b_valid_q;
  assign word_if.inst  = b_inst_q;
  assign word_if.err   = b_err_q;
  assign word_if.addr  = addr_q;
  assign err_cnt_o     = err_cnt_q;

endmodule

// File: doc/inst_encoder.md
Name: inst_encoder

Overview:
- Streaming RV32 instruction encoder; the inverse of the ID-stage immediate extraction. Packs format, register, funct and immediate fields into 32-bit instruction words.
- Used by the test/boot loader to fill instruction memory. Emits words with a byte address (PC-style, +4 per word).
- 2-stage pipeline with valid/ready on both sides; range-checks immediates and flags errors per word.

Parameters:
- ADDR_W, 32, width of the address output.
- BASE_ADDR, 0, address of the first emitted word after reset or clear.
- NOP_WORD, 32'h00000013, word emitted in place of any erroneous instruction.

Ports:
- clk_i  in  1  clock, all state on rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- clear_i  in  1  synchronous flush: empties the pipeline, reloads address, zeroes the error count.
- valid_i  in  1  input field set valid.
- ready_o  out  1  encoder accepts the input this cycle.
- fmt_i  in  3  format: 0 R, 1 I-ALU, 2 LD, 3 SD, 4 BEQ; 5-7 illegal.
- rd_i, rs1_i, rs2_i  in  5 each  register fields.
- funct3_i  in  3  funct3 field.
- funct7_i  in  7  funct7 field (R only).
- imm_i  in  32  signed immediate. BEQ: offset in halfwords (byte offset / 2).
- valid_o  out  1  output word valid.
- ready_i  in  1  downstream accepts the output word.
- inst_o  out  32  encoded instruction.
- addr_o  out  ADDR_W  byte address of inst_o.
- err_o  out  1  current inst_o replaced by NOP_WORD.
- err_cnt_o  out  8  saturating count of error words emitted.

Behaviour:
- Reset (rst_i low, async):
  - Both stages invalid: valid_o=0, inst_o=0, err_o=0.
  - addr_o=BASE_ADDR, err_cnt_o=0.
  - ready_o=1 once reset is released.
- Stage A registers the input fields and computes `ok`.
  - ok = fmt legal AND (fmt==0 OR imm_i[31:11] all equal to imm_i[11]), i.e. -2048..2047.
  - Stage A loads when valid_i & ready_o.
- Stage B registers the encoded word and err flag.
  - B loads from A when A valid and (B empty or ready_i).
- ready_o = !A_valid | !B_valid | ready_i.
- Throughput 1 word/cycle. Latency from input accept to valid_o is 2 cycles.
- Encodings (opcode in [6:0]):
  - R 0110011: {funct7, rs2, rs1, funct3, rd}; imm ignored.
  - I 0010011 / LD 0000011: [31:20]=imm[11:0], [19:15]=rs1, [14:12]=funct3, [11:7]=rd.
  - SD 0100011: [31:25]=imm[11:5], [24:20]=rs2, [19:15]=rs1, [14:12]=funct3, [11:7]=imm[4:0].
  - BEQ 1100011:
    - [31]=imm[11], [7]=imm[10], [30:25]=imm[9:4], [11:8]=imm[3:0].
    - [24:20]=rs2, [19:15]=rs1, [14:12]=funct3.
- Error handling: !ok gives inst_o=NOP_WORD and err_o=1. The error word still consumes an address.
- Output holds:
  - valid_o, inst_o, addr_o and err_o stay stable while valid_o & !ready_i.
  - valid_o never drops without a handshake.
- Address counter:
  - addr_o advances by 4 on each output handshake (valid_o & ready_i).
  - Wraps modulo 2^ADDR_W with no flag.
- err_cnt_o increments on the handshake of an err word and saturates at 255.
- clear_i has priority over all handshakes in that cycle:
  - A and B invalidated; in-flight words are dropped, not emitted.
  - addr=BASE_ADDR, err_cnt=0.
- Simultaneous B drain and A refill in the same cycle is legal; no bubble.
- Reset asserted mid-stream: everything is lost; output returns to reset values immediately.

Test Plan:
- I-ALU addi: rd=1, rs1=0, funct3=0, imm=-1 → inst_o=32'hFFF00093, addr_o=0, err_o=0, valid_o exactly 2 cycles after accept.
- SD: rs2=5, rs1=2, funct3=3, imm=8 → 32'h00513423. BEQ: rs1=1, rs2=2, funct3=0, imm=-2 → 32'hFE208EE3 (round-trip: decoded immediate equals -2).
- Range: LD imm=2048 → inst_o=32'h00000013, err_o=1, err_cnt_o=1. fmt=6 → same. R-format with imm=32'h7FFFFFFF → no error.
- Backpressure: 4 back-to-back inputs, ready_i low for 3 cycles after the first valid_o.
  - ready_o drops once both stages are full; held output stable.
  - All 4 words emitted in order at addresses 0, 4, 8, 12.
- Wrap/clear:
  - ADDR_W=4, BASE_ADDR=12: second word at addr 0.
  - clear_i with 2 words in flight → no valid_o, next word at BASE_ADDR, err_cnt_o=0.
- Async reset asserted mid-stream, no clock edge → valid_o=0 immediately. Saturation: 300 error words → err_cnt_o=255.
